// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the memory access unit: ME_* width codes, FSM states, lane constants.
package mem_access_unit_pkg;

  localparam logic [2:0] ME_LW  = 3'b000;
  localparam logic [2:0] ME_LH  = 3'b001;
  localparam logic [2:0] ME_LHU = 3'b010;
  localparam logic [2:0] ME_LB  = 3'b011;
  localparam logic [2:0] ME_LBU = 3'b100;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    MA_IDLE = 2'b00,
    MA_REQ  = 2'b01,
    MA_DONE = 2'b10,
    MA_FAIL = 2'b11
  } ma_state_e;

  typedef enum logic [1:0] {
    W_BYTE = 2'b00,
    W_HALF = 2'b01,
    W_WORD = 2'b10
  } width_e;

  // Unlisted codes fall back to a full-word access.
  function automatic width_e width_of(input logic [2:0] op);
    case (op)
      ME_LH, ME_LHU: width_of = W_HALF;
      ME_LB, ME_LBU: width_of = W_BYTE;
      default:       width_of = W_WORD;
    endcase
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane steering: byte enables, replicated store data and the alignment check.
module store_lane_align
  import mem_access_unit_pkg::*;
(
  input  width_e      width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misalign_o
);

  always_comb begin
    be_o       = BE_ALL;
    wdata_o    = wdata_i;
    misalign_o = 1'b0;
    case (width_i)
      W_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      W_HALF: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        misalign_o = addr_lo_i[0];
      end
      default: begin
        misalign_o = |addr_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store bus master: alignment check, lane steering, req/ack handshake with timeout, MDR capture.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        mem_we,
  input  logic [2:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misalign,
  output logic        bus_err,
  output logic [31:0] rdata,
  output logic [1:0]  addr_lo,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  ma_state_e   state_q;
  logic [CNT_W-1:0] cnt_q;
  logic        req_q, we_q, done_q, mis_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  be_q;
  logic [1:0]  addr_lo_q;

  width_e      width_d;
  logic [3:0]  st_be_d;
  logic [31:0] st_wdata_d;
  logic        mis_d;
  logic        timeout_hit;

  assign width_d = width_of(mem_op);

  store_lane_align u_align (
    .width_i    (width_d),
    .addr_lo_i  (addr[1:0]),
    .wdata_i    (wdata),
    .be_o       (st_be_d),
    .wdata_o    (st_wdata_d),
    .misalign_o (mis_d)
  );

  // Fires on the last of TIMEOUT cycles in REQ; a same-cycle ack still wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MA_IDLE;
      cnt_q     <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      done_q    <= 1'b0;
      mis_q     <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      be_q      <= '0;
      addr_lo_q <= '0;
    end else begin
      case (state_q)
        MA_IDLE: begin
          if (start) begin
            we_q      <= mem_we;
            addr_q    <= {addr[31:2], 2'b00};
            be_q      <= mem_we ? st_be_d : BE_ALL;
            wdata_q   <= st_wdata_d;
            addr_lo_q <= addr[1:0];
            mis_q     <= mis_d;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            if (mis_d) begin
              state_q <= MA_FAIL;
              done_q  <= 1'b1;
            end else begin
              state_q <= MA_REQ;
              req_q   <= 1'b1;
            end
          end
        end
        MA_REQ: begin
          if (bus_ack) begin
            if (!we_q) rdata_q <= bus_rdata;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
            state_q <= MA_DONE;
          end else if (timeout_hit) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= MA_FAIL;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= MA_IDLE;
        end
      endcase
    end
  end

  assign busy      = (state_q != MA_IDLE);
  assign done      = done_q;
  assign misalign  = mis_q;
  assign bus_err   = err_q;
  assign rdata     = rdata_q;
  assign addr_lo   = addr_lo_q;
  assign bus_req   = req_q;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_be    = be_q;
  assign bus_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit with TIMEOUT=4.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n, start, mem_we, bus_ack;
  logic [2:0]  mem_op;
  logic [31:0] addr, wdata, bus_rdata;
  logic        busy, done, misalign, bus_err, bus_req, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [1:0]  addr_lo;
  logic [3:0]  bus_be;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mis;
    logic        err;
    logic [31:0] rdata;
    logic [1:0]  alo;
    logic        we;
    logic [31:0] ba;
    logic [3:0]  be;
    logic [31:0] wd;
    int          done_cyc;
    int          req_cyc;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdr_model;

  mem_access_unit #(.TIMEOUT(TO), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_we(mem_we), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .misalign(misalign),
    .bus_err(bus_err), .rdata(rdata), .addr_lo(addr_lo), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. waits<0 means never ack; poke re-pulses start during REQ.
  task automatic access(input logic we, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] wd, input int waits, input logic [31:0] brd,
                        input logic [3:0] ebe, input logic [31:0] ewd,
                        input logic emis, input logic eerr, input bit poke);
    exp_t e, got;
    int   cyc, reqc;
    bit   seen;
    e.mis   = emis;
    e.err   = eerr;
    e.rdata = (!we && !emis && !eerr) ? brd : mdr_model;
    mdr_model = e.rdata;
    e.alo   = a[1:0];
    e.we    = we;
    e.ba    = {a[31:2], 2'b00};
    e.be    = ebe;
    e.wd    = ewd;
    e.done_cyc = emis ? 1 : (eerr ? TO + 1 : waits + 2);
    e.req_cyc  = emis ? 0 : (eerr ? TO : waits + 1);
    sb.push_back(e);

    mem_we = we; mem_op = op; addr = a; wdata = wd; start = 1'b1;
    cyc = 0; reqc = 0; seen = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = 1'b0; bus_ack = 1'b0; bus_rdata = 32'h0BAD_0BAD;
      if (bus_req) begin
        reqc++;
        chk("bus_addr", bus_addr, sb[0].ba);
        chk("bus_be", {28'd0, bus_be}, {28'd0, sb[0].be});
        chk("bus_we", {31'd0, bus_we}, {31'd0, sb[0].we});
        if (sb[0].we) chk("bus_wdata", bus_wdata, sb[0].wd);
        if (waits >= 0 && reqc == waits + 1) begin
          bus_ack = 1'b1; bus_rdata = brd;
        end
        if (poke) begin
          start = 1'b1; addr = 32'hFFFF_FFF1; mem_op = ME_LB; mem_we = 1'b0;
        end
      end
      if (done) begin
        seen = 1;
        got = sb.pop_front();
        chk("done_cycle", cyc, got.done_cyc);
        chk("req_cycles", reqc, got.req_cyc);
        chk("misalign", {31'd0, misalign}, {31'd0, got.mis});
        chk("bus_err", {31'd0, bus_err}, {31'd0, got.err});
        chk("rdata", rdata, got.rdata);
        chk("addr_lo", {30'd0, addr_lo}, {30'd0, got.alo});
        chk("busy_at_done", {31'd0, busy}, 32'd1);
      end
    end
    if (!seen) begin
      chk("done_seen", 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    chk("idle_after", {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mem_we = 1'b0; mem_op = ME_LW;
    addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
    mdr_model = '0;
    repeat (2) @(negedge clk);
    chk("rst_outs", {busy, done, misalign, bus_err, bus_req, bus_we, bus_be}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus", bus_addr | bus_wdata | {30'd0, addr_lo}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    bus_ack = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_ack = 1'b0;
    chk("stray_ack", {31'd0, busy}, 32'd0);
    chk("stray_ack_rdata", rdata, 32'd0);

    access(1'b0, ME_LW,  32'h0000_0100, 32'h0,         0, 32'hDEAD_BEEF, 4'hF, 32'h0,         1'b0, 1'b0, 0);
    access(1'b1, ME_LB,  32'h0000_0203, 32'h0000_00A5, 3, 32'h1111_1111, 4'h8, 32'hA5A5_A5A5, 1'b0, 1'b0, 0);
    access(1'b1, ME_LH,  32'h0000_0102, 32'h0000_BEEF, 1, 32'h2222_2222, 4'hC, 32'hBEEF_BEEF, 1'b0, 1'b0, 0);
    access(1'b1, ME_LH,  32'h0000_0100, 32'h1234_5678, 0, 32'h0,         4'h3, 32'h5678_5678, 1'b0, 1'b0, 0);
    access(1'b1, ME_LBU, 32'h0000_0200, 32'h0000_003C, 0, 32'h0,         4'h1, 32'h3C3C_3C3C, 1'b0, 1'b0, 0);
    access(1'b0, ME_LH,  32'h0000_0101, 32'h0,         0, 32'h3333_3333, 4'hF, 32'h0,         1'b1, 1'b0, 0);
    access(1'b1, ME_LW,  32'h0000_0102, 32'hFFFF_0000, 0, 32'h0,         4'hF, 32'h0,         1'b1, 1'b0, 0);
    access(1'b0, ME_LB,  32'h0000_0101, 32'h0,         2, 32'hCAFE_F00D, 4'hF, 32'h0,         1'b0, 1'b0, 0);
    access(1'b0, ME_LW,  32'h0000_0300, 32'h0,        -1, 32'h0,         4'hF, 32'h0,         1'b0, 1'b1, 0);
    access(1'b1, ME_LW,  32'h0000_0400, 32'h89AB_CDEF, 2, 32'h0,         4'hF, 32'h89AB_CDEF, 1'b0, 1'b0, 1);

    mem_we = 1'b0; mem_op = ME_LW; addr = 32'h0000_0500; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_req_drop", {30'd0, bus_req, busy}, 32'd0);
    chk("rst_mdr", rdata, 32'd0);
    mdr_model = '0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_no_done", {31'd0, done}, 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    access(1'b0, ME_LHU, 32'h0000_0202, 32'h0,         1, 32'h55AA_55AA, 4'hF, 32'h0,         1'b0, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
